// File: rtl/usb_proto_pkg.sv
// Shared definitions for the USB status/response path: packet constants,
// response FSM state encoding and the layout of the settings word (W2).
// Optional feature macro: USB_STATUS_CHECKSUM_EN (adds checksum word W4).
package usb_proto_pkg;

  localparam logic [15:0] HEADER_DEFAULT          = 16'hAA55;
  localparam logic [15:0] STATUS_REQ_CODE_DEFAULT = 16'hD000;

  localparam int PKT_LEN_BASE = 4;
  localparam int PKT_LEN_CSUM = 5;

  // Response FSM states; the checksum state exists only when compiled in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_W3
`ifdef USB_STATUS_CHECKSUM_EN
    ,ST_W4
`endif
  } state_t;

  // Field positions inside W2 (settings word).
  localparam int W2_LED_LSB = 12;
  localparam int W2_AVG_LSB = 4;
  localparam int W2_CH_LSB  = 0;

  // Build W2 = {LED, 4'h0, 2'b00, avg, 2'b00, channel}.
  function automatic logic [15:0] pack_w2(input logic [3:0] led,
                                          input logic [1:0] avg,
                                          input logic [1:0] ch);
    logic [15:0] w;
    w = 16'h0000;
    w[W2_LED_LSB +: 4] = led;
    w[W2_AVG_LSB +: 2] = avg;
    w[W2_CH_LSB  +: 2] = ch;
    return w;
  endfunction

endpackage

// File: rtl/usb_resp_queue.sv
// Request slots for the status transmitter: a one-deep command slot, a sticky
// status flag and a saturating drop counter. Commands beat status requests.
//
// Handshake: req_valid is high while any slot is pending; req_is_cmd/req_word
// describe the winning request. A one-cycle req_take consumes that request on
// the next edge. A request arriving on the same edge as its slot is consumed
// becomes the new pending entry.
module usb_resp_queue
  import usb_proto_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_cmd_valid,
  input  logic [15:0] in_cmd_word,
  input  logic        in_status_req,
  input  logic        req_take,
  output logic        req_valid,
  output logic        req_is_cmd,
  output logic [15:0] req_word,
  output logic [7:0]  drop_cnt
);

  logic        cmd_pending;
  logic [15:0] cmd_word;
  logic        stat_pending;
  logic        take_cmd;
  logic        take_stat;

  assign req_valid  = cmd_pending | stat_pending;
  assign req_is_cmd = cmd_pending;
  assign req_word   = cmd_word;
  assign take_cmd   = req_take & cmd_pending;
  assign take_stat  = req_take & ~cmd_pending & stat_pending;

  // Command slot and drop counter: a new command lands if the slot is free or
  // being consumed this edge, otherwise it is counted as a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_pending <= 1'b0;
      cmd_word    <= 16'h0000;
      drop_cnt    <= 8'h00;
    end else if (in_cmd_valid) begin
      if (!cmd_pending || take_cmd) begin
        cmd_pending <= 1'b1;
        cmd_word    <= in_cmd_word;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (take_cmd) begin
      cmd_pending <= 1'b0;
    end
  end

  // Status flag: repeated requests merge; a new request wins over a take.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_pending <= 1'b0;
    end else if (in_status_req) begin
      stat_pending <= 1'b1;
    end else if (take_stat) begin
      stat_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/usb_status_transmitter.sv
// Builds fixed-format response packets (header, echo, settings, seq/drops and
// optionally a checksum) and writes them word-by-word into the USB IN FIFO,
// stalling while the FIFO reports almost-full.
// Optional feature macro: USB_STATUS_CHECKSUM_EN (appends W4 = W1^W2^W3).
//
// Handshake: out_to_usb_wr_en high for one cycle means out_to_usb_data holds
// one packet word; the FIFO full flag is sampled one edge before the write
// appears, so the FIFO must assert it with at least one word of slack.
module usb_status_transmitter
  import usb_proto_pkg::*;
#(
  parameter logic [15:0] HEADER          = HEADER_DEFAULT,
  parameter logic [15:0] STATUS_REQ_CODE = STATUS_REQ_CODE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_cmd_valid,
  input  logic [15:0] in_cmd_word,
  input  logic        in_status_req,
  input  logic [1:0]  Channel_Select,
  input  logic [1:0]  in_average_points,
  input  logic [3:0]  LED,
  input  logic        in_from_usb_fifo_full,
  output logic [15:0] out_to_usb_data,
  output logic        out_to_usb_wr_en,
  output logic        out_busy
);

  state_t      state;
  logic        req_valid;
  logic        req_is_cmd;
  logic [15:0] req_word;
  logic [7:0]  drop_cnt;
  logic        req_take;
  logic [15:0] w1_q;
  logic [15:0] w2_q;
  logic [15:0] w3_q;
  logic [7:0]  seq;

  // The queue's slot is consumed on the edge leaving LOAD, after the snapshot.
  assign req_take = (state == ST_LOAD);

  usb_resp_queue u_queue (
    .clk           (clk),
    .reset         (reset),
    .in_cmd_valid  (in_cmd_valid),
    .in_cmd_word   (in_cmd_word),
    .in_status_req (in_status_req),
    .req_take      (req_take),
    .req_valid     (req_valid),
    .req_is_cmd    (req_is_cmd),
    .req_word      (req_word),
    .drop_cnt      (drop_cnt)
  );

  // Packet FSM with registered outputs; each word state writes only when the
  // FIFO is not full, otherwise it holds with the strobe low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      out_to_usb_data  <= 16'h0000;
      out_to_usb_wr_en <= 1'b0;
      out_busy         <= 1'b0;
      w1_q             <= 16'h0000;
      w2_q             <= 16'h0000;
      w3_q             <= 16'h0000;
      seq              <= 8'h00;
    end else begin
      out_to_usb_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Incoming pulses are looked at directly so LOAD follows the
          // request edge without an extra cycle.
          if (req_valid || in_cmd_valid || in_status_req) begin
            state    <= ST_LOAD;
            out_busy <= 1'b1;
          end
        end
        ST_LOAD: begin
          w1_q  <= req_is_cmd ? req_word : STATUS_REQ_CODE;
          w2_q  <= pack_w2(LED, in_average_points, Channel_Select);
          w3_q  <= {seq, drop_cnt};
          state <= ST_W0;
        end
        ST_W0: begin
          if (!in_from_usb_fifo_full) begin
            out_to_usb_wr_en <= 1'b1;
            out_to_usb_data  <= HEADER;
            state            <= ST_W1;
          end
        end
        ST_W1: begin
          if (!in_from_usb_fifo_full) begin
            out_to_usb_wr_en <= 1'b1;
            out_to_usb_data  <= w1_q;
            state            <= ST_W2;
          end
        end
        ST_W2: begin
          if (!in_from_usb_fifo_full) begin
            out_to_usb_wr_en <= 1'b1;
            out_to_usb_data  <= w2_q;
            state            <= ST_W3;
          end
        end
        ST_W3: begin
          if (!in_from_usb_fifo_full) begin
            out_to_usb_wr_en <= 1'b1;
            out_to_usb_data  <= w3_q;
`ifdef USB_STATUS_CHECKSUM_EN
            state            <= ST_W4;
`else
            state            <= ST_IDLE;
            out_busy         <= 1'b0;
            seq              <= seq + 8'd1;
`endif
          end
        end
`ifdef USB_STATUS_CHECKSUM_EN
        ST_W4: begin
          if (!in_from_usb_fifo_full) begin
            out_to_usb_wr_en <= 1'b1;
            out_to_usb_data  <= w1_q ^ w2_q ^ w3_q;
            state            <= ST_IDLE;
            out_busy         <= 1'b0;
            seq              <= seq + 8'd1;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
